// File: rtl/alu_exec_unit.sv
// EX-stage ALU with valid/ready handshakes on both sides; shifts are iterative unless
// ALU_BARREL_SHIFT_EN is defined, in which case every op completes in one cycle.
module alu_exec_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      ALU_Ctrl,
  input  logic [XLEN-1:0] Operand_A,
  input  logic [XLEN-1:0] Operand_B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALU_Result,
  output logic            ALU_Zero,
  output logic            ALU_Illegal
);

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shift_kind_t;

  state_t          state;
  shift_kind_t     shift_kind;
  shift_kind_t     comb_kind;
  logic [XLEN-1:0] shift_val;
  logic [4:0]      shift_rem;
  logic [4:0]      step_amt;
  logic [4:0]      shamt;
  logic [XLEN-1:0] comb_result;
  logic            comb_illegal;
  logic            is_shift;
  logic            start_shift;
  logic            accept;
  logic [XLEN-1:0] sra_full;
  logic [XLEN-1:0] sra_step;
  logic [XLEN-1:0] shifted;

  assign shamt       = Operand_B[4:0];
  assign in_ready    = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept      = in_valid && in_ready && !flush;
  assign start_shift = is_shift && (shamt != 5'd0) && !BARREL;

  // Arithmetic shifts kept as standalone assigns so a surrounding ?: cannot strip the sign.
  assign sra_full = $signed(Operand_A) >>> shamt;
  assign sra_step = $signed(shift_val) >>> step_amt;
  assign step_amt = (shift_rem < STEP) ? shift_rem : STEP;

  always_comb begin
    comb_result  = '0;
    comb_illegal = 1'b0;
    is_shift     = 1'b0;
    comb_kind    = SK_SLL;
    case (ALU_Ctrl)
      5'd1, 5'd2:   comb_result = Operand_A + Operand_B;
      5'd3, 5'd4:   comb_result = Operand_A | Operand_B;
      5'd5, 5'd6:   comb_result = Operand_A ^ Operand_B;
      5'd7, 5'd8:   comb_result = Operand_A & Operand_B;
      5'd9:         comb_result = Operand_A - Operand_B;
      5'd10, 5'd11: comb_result = XLEN'($signed(Operand_A) < $signed(Operand_B));
      5'd12, 5'd13: comb_result = XLEN'(Operand_A < Operand_B);
      5'd14, 5'd17: begin
        is_shift    = 1'b1;
        comb_kind   = SK_SLL;
        comb_result = BARREL ? (Operand_A << shamt) : Operand_A;
      end
      5'd15, 5'd18: begin
        is_shift    = 1'b1;
        comb_kind   = SK_SRL;
        comb_result = BARREL ? (Operand_A >> shamt) : Operand_A;
      end
      5'd16, 5'd19: begin
        is_shift    = 1'b1;
        comb_kind   = SK_SRA;
        comb_result = BARREL ? sra_full : Operand_A;
      end
      default:      comb_illegal = 1'b1;
    endcase
  end

  always_comb begin
    shifted = '0;
    case (shift_kind)
      SK_SLL:  shifted = shift_val << step_amt;
      SK_SRL:  shifted = shift_val >> step_amt;
      default: shifted = sra_step;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      ALU_Result  <= '0;
      ALU_Zero    <= 1'b0;
      ALU_Illegal <= 1'b0;
      shift_val   <= '0;
      shift_rem   <= '0;
      shift_kind  <= SK_SLL;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (start_shift) begin
        state      <= SHIFT;
        out_valid  <= 1'b0;
        shift_val  <= Operand_A;
        shift_rem  <= shamt;
        shift_kind <= comb_kind;
      end else begin
        state       <= DONE;
        out_valid   <= 1'b1;
        ALU_Result  <= comb_result;
        ALU_Zero    <= (comb_result == '0);
        ALU_Illegal <= comb_illegal;
      end
    end else begin
      case (state)
        SHIFT: begin
          shift_val <= shifted;
          shift_rem <= shift_rem - step_amt;
          // The final partial step publishes directly so DONE is entered as remaining hits zero.
          if (shift_rem <= STEP) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            ALU_Result  <= shifted;
            ALU_Zero    <= (shifted == '0);
            ALU_Illegal <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a spec-level model with a per-cycle compare process,
// plus literal expectations for the documented vectors.
module tb_alu_exec_unit;
  localparam int unsigned XLEN = 32;
  localparam int unsigned STEP = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      ALU_Ctrl = '0;
  logic [XLEN-1:0] Operand_A = '0;
  logic [XLEN-1:0] Operand_B = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] ALU_Result;
  logic            ALU_Zero;
  logic            ALU_Illegal;

  alu_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALU_Ctrl(ALU_Ctrl), .Operand_A(Operand_A), .Operand_B(Operand_B),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Result(ALU_Result), .ALU_Zero(ALU_Zero), .ALU_Illegal(ALU_Illegal)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  int unsigned last_acc = 0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int unsigned due;
  } exp_t;
  exp_t q[$];
  bit head_seen = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa, sb, t;
    logic [4:0] sh;
    sa = a; sb = b; sh = b[4:0];
    t = sa >>> sh;
    case (op)
      5'd1, 5'd2:   return {1'b0, a + b};
      5'd3, 5'd4:   return {1'b0, a | b};
      5'd5, 5'd6:   return {1'b0, a ^ b};
      5'd7, 5'd8:   return {1'b0, a & b};
      5'd9:         return {1'b0, a - b};
      5'd10, 5'd11: return {1'b0, 31'd0, sa < sb};
      5'd12, 5'd13: return {1'b0, 31'd0, a < b};
      5'd14, 5'd17: return {1'b0, a << sh};
      5'd15, 5'd18: return {1'b0, a >> sh};
      5'd16, 5'd19: return {1'b0, t};
      default:      return {1'b1, 32'd0};
    endcase
  endfunction

  // Cycles beyond the single base cycle before the result appears.
  function automatic int unsigned extra(input logic [4:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return (op == 5'd0 && b == 32'd0) ? 0 : 0;
`else
    if (op >= 5'd14 && op <= 5'd19 && b[4:0] != 5'd0)
      return (32'(b[4:0]) + STEP - 1) / STEP;
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (reset || flush) begin
      q.delete();
      head_seen = 1'b0;
    end else if (q.size() == 0) begin
      check1("idle_out_valid", out_valid, 1'b0);
      check1("idle_in_ready", in_ready, 1'b1);
    end else begin
      if (!head_seen) begin
        check1("out_valid_timing", out_valid, cyc >= q[0].due);
        if (out_valid) head_seen = 1'b1;
        else check1("busy_in_ready", in_ready, 1'b0);
      end
      if (out_valid) begin
        check32("model_result", ALU_Result, q[0].res);
        check1("model_zero", ALU_Zero, q[0].res == 32'd0);
        check1("model_illegal", ALU_Illegal, q[0].ill);
        check1("done_in_ready", in_ready, out_ready);
        if (out_ready) begin
          void'(q.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    exp_t e;
    logic [32:0] m;
    in_valid = 1'b1; ALU_Ctrl = op; Operand_A = a; Operand_B = b;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_ready && !flush) && n < 100);
    if (n >= 100) check1("accept_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    m = model(op, a, b);
    e.res = m[31:0];
    e.ill = m[32];
    e.due = cyc + extra(op, b);
    q.push_back(e);
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [31:0] exp_res, input logic exp_zero,
                          input logic exp_ill, input int unsigned exp_lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    check1({name, "_valid"}, out_valid, 1'b1);
    check32({name, "_res"}, ALU_Result, exp_res);
    check1({name, "_zero"}, ALU_Zero, exp_zero);
    check1({name, "_ill"}, ALU_Illegal, exp_ill);
    check32({name, "_lat"}, cyc - last_acc + 1, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check32("drain_empty", 32'(q.size()), 32'd0);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vecs[10] = '{
    '{5'd6,  32'hDEAD_BEEF, 32'h0000_FFFF},
    '{5'd7,  32'hF0F0_1234, 32'h0FF0_FF00},
    '{5'd3,  32'hF0F0_0000, 32'h0000_0F0F},
    '{5'd15, 32'h8000_00F0, 32'h0000_0007},
    '{5'd17, 32'h0000_0003, 32'hFFFF_FFFF},
    '{5'd19, 32'h9000_0000, 32'h0000_0011},
    '{5'd13, 32'h0000_0001, 32'hFFFF_FFFF},
    '{5'd2,  32'hFFFF_FFFF, 32'h0000_0001},
    '{5'd20, 32'h0000_0005, 32'h0000_0005},
    '{5'd31, 32'h1234_5678, 32'h0000_0000}
  };

  int unsigned rel;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_result", ALU_Result, 32'd0);
    check1("rst_zero", ALU_Zero, 1'b0);
    check1("rst_illegal", ALU_Illegal, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;

    issue(5'd1, 32'd5, 32'd7);                 wait_out("add", 32'd12, 1'b0, 1'b0, 1);
    issue(5'd9, 32'd3, 32'd5);                 wait_out("sub", 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    issue(5'd9, 32'h1234, 32'h1234);           wait_out("sub_eq", 32'd0, 1'b1, 1'b0, 1);
    issue(5'd10, 32'hFFFF_FFFF, 32'd1);        wait_out("slt", 32'd1, 1'b0, 1'b0, 1);
    issue(5'd12, 32'hFFFF_FFFF, 32'd1);        wait_out("sltu", 32'd0, 1'b1, 1'b0, 1);
    issue(5'd11, 32'hFFFF_FFF8, 32'hFFFF_FFFC); wait_out("slti", 32'd1, 1'b0, 1'b0, 1);
`ifdef ALU_BARREL_SHIFT_EN
    issue(5'd16, 32'h8000_0000, 32'd4);        wait_out("sra", 32'hF800_0000, 1'b0, 1'b0, 1);
`else
    issue(5'd16, 32'h8000_0000, 32'd4);        wait_out("sra", 32'hF800_0000, 1'b0, 1'b0, 5);
`endif
    issue(5'd14, 32'h1234_5678, 32'h20);       wait_out("sll0", 32'h1234_5678, 1'b0, 1'b0, 1);
    issue(5'd0, 32'd9, 32'd9);                 wait_out("ill0", 32'd0, 1'b1, 1'b1, 1);
    issue(5'd25, 32'd9, 32'd9);                wait_out("ill25", 32'd0, 1'b1, 1'b1, 1);

    for (int i = 0; i < 10; i++) issue(vecs[i].op, vecs[i].a, vecs[i].b);
    drain();

    out_ready = 1'b0;
    issue(5'd1, 32'd100, 32'd23);              wait_out("stall_add", 32'd123, 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("stall_hold", ALU_Result, 32'd123);
      check1("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    fork
      issue(5'd5, 32'hFF00_FF00, 32'h0FF0_0FF0);
      begin
        repeat (2) @(posedge clk);
        #1;
        rel = cyc;
        out_ready = 1'b1;
      end
    join
    check32("b2b_accept_cycle", last_acc, rel + 1);
    wait_out("xor", 32'hF0F0_F0F0, 1'b0, 1'b0, 1);

    issue(5'd15, 32'hF000_0000, 32'd20);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; ALU_Ctrl = 5'd1; Operand_A = 32'd1; Operand_B = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check1("flush_in_ready", in_ready, 1'b1);
    check1("flush_no_valid", out_valid, 1'b0);
    check32("flush_keep_result", ALU_Result, 32'hF0F0_F0F0);
    repeat (25) @(posedge clk);
    #1;

    issue(5'd15, 32'hF000_0000, 32'd20);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check1("midrst_out_valid", out_valid, 1'b0);
    check32("midrst_result", ALU_Result, 32'd0);
    check1("midrst_zero", ALU_Zero, 1'b0);
    check1("midrst_illegal", ALU_Illegal, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    issue(5'd2, 32'd40, 32'd2);                wait_out("post_rst_addi", 32'd42, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
